// File: rtl/emu_ckpt_pkg.sv
// rtl/emu_ckpt_pkg.sv - shared types for the emulator RAM checkpoint controller
package emu_ckpt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_PRE,
    ST_XFER,
    ST_TAIL,
    ST_POST,
    ST_REL
  } ckpt_state_e;

  localparam logic DIR_DUMP    = 1'b0;
  localparam logic DIR_RESTORE = 1'b1;

endpackage

// File: rtl/emu_ram_ckpt_ctrl.sv
// rtl/emu_ram_ckpt_ctrl.sv - one halted RAM scan-chain dump or restore pass
module emu_ram_ckpt_ctrl
  import emu_ckpt_pkg::*;
#(
  parameter int DW          = 64,
  parameter int CHAIN_WORDS = 128,
  parameter int RD_LAT      = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_dir,
  output logic          busy,
  output logic          done,
  output logic          err_unf,
  output logic          emu_halt,
  output logic          ram_scan,
  output logic          ram_dir,
  output logic [DW-1:0] ram_sdi,
  input  logic [DW-1:0] ram_sdo,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data
);

  localparam int CW = $clog2(CHAIN_WORDS + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(CHAIN_WORDS - 1);
  localparam logic [CW-1:0] LAST_PRE  = CW'(RD_LAT - 1);

  ckpt_state_e   state_q, state_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_DUMP;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        cnt_d   = '0;
        state_d = ST_PRE;
      end
      ST_PRE: begin
        // Dump waits out the SDO pipeline; restore waits for the first input word.
        if (dir_q == DIR_DUMP) begin
          if (cnt_q == LAST_PRE) begin
            cnt_d   = '0;
            state_d = ST_XFER;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (in_valid) begin
          cnt_d   = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        // The chain shifts every cycle regardless, so a missing word is flagged, not stalled.
        if (dir_q == DIR_RESTORE && !in_valid) begin
          err_d = 1'b1;
        end
        if (cnt_q == LAST_WORD) begin
          cnt_d   = '0;
          state_d = ST_TAIL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_TAIL: state_d = ST_POST;
      ST_POST: state_d = ST_REL;
      ST_REL:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_REL);
    err_unf     = err_q;
    emu_halt    = (state_q == ST_HALT) || (state_q == ST_PRE) || (state_q == ST_XFER) ||
                  (state_q == ST_TAIL) || (state_q == ST_POST);
    ram_scan    = ((state_q == ST_PRE) && (dir_q == DIR_DUMP)) ||
                  (state_q == ST_XFER) || (state_q == ST_TAIL);
    ram_dir     = ((state_q == ST_PRE) || (state_q == ST_XFER) ||
                   (state_q == ST_TAIL) || (state_q == ST_POST)) ? dir_q : 1'b0;
    in_ready    = (state_q == ST_XFER) && (dir_q == DIR_RESTORE);
    ram_sdi     = (in_ready && in_valid) ? in_data : '0;
    out_valid_d = (state_q == ST_XFER) && (dir_q == DIR_DUMP);
    out_data_d  = out_valid_d ? ram_sdo : out_data_q;
    out_valid   = out_valid_q;
    out_data    = out_data_q;
  end

endmodule

// File: tb/tb_emu_ram_ckpt_ctrl.sv
// tb/tb_emu_ram_ckpt_ctrl.sv - scoreboard bench with a behavioural RAM scan chain
module tb_emu_ram_ckpt_ctrl;
  import emu_ckpt_pkg::*;

  localparam int DW  = 64;
  localparam int NW  = 128;
  localparam int RDL = 2;

  logic          clk = 1'b0;
  logic          rst_n, cmd_valid, cmd_dir;
  logic          cmd_ready, busy, done, err_unf, emu_halt, ram_scan, ram_dir;
  logic [DW-1:0] ram_sdi, ram_sdo, out_data, in_data;
  logic          out_valid, in_valid, in_ready;

  always #5 clk = ~clk;

  emu_ram_ckpt_ctrl #(.DW(DW), .CHAIN_WORDS(NW), .RD_LAT(RDL)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .busy(busy), .done(done), .err_unf(err_unf),
    .emu_halt(emu_halt), .ram_scan(ram_scan), .ram_dir(ram_dir),
    .ram_sdi(ram_sdi), .ram_sdo(ram_sdo), .out_valid(out_valid), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  // Scan chain: SDO word k appears RDL cycles after shifting starts; SDI words land in order.
  logic [DW-1:0] chain    [NW];
  logic [DW-1:0] load_buf [NW];
  logic          load_req = 1'b0;
  logic [7:0]    rd_cnt = 8'd0, wr_cnt = 8'd0;
  logic [6:0]    rd_idx;

  assign rd_idx  = 7'(rd_cnt - 8'(RDL));
  assign ram_sdo = (ram_scan && !ram_dir && rd_cnt >= 8'(RDL) && rd_cnt < 8'(RDL + NW)) ?
                   chain[rd_idx] : '0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < NW; i++) chain[i] <= load_buf[i];
    end else if (ram_scan && ram_dir && wr_cnt < 8'(NW)) begin
      chain[wr_cnt[6:0]] <= ram_sdi;
    end
    rd_cnt <= (ram_scan && !ram_dir) ? rd_cnt + 8'd1 : 8'd0;
    wr_cnt <= (ram_scan && ram_dir) ? wr_cnt + 8'd1 : 8'd0;
  end

  // Restore word source with an optional hole at transfer slot 5.
  logic [DW-1:0] src_buf [NW];
  logic          src_en = 1'b0, src_rst = 1'b0, gap_en = 1'b0;
  logic [7:0]    src_idx = 8'd0, rdy_cnt = 8'd0;

  assign in_valid = src_en && !(gap_en && rdy_cnt == 8'd5);
  assign in_data  = src_buf[src_idx[6:0]];

  always @(posedge clk) begin
    if (src_rst) begin
      src_idx <= 8'd0;
      rdy_cnt <= 8'd0;
    end else begin
      if (in_ready && in_valid) src_idx <= src_idx + 8'd1;
      if (in_ready) rdy_cnt <= rdy_cnt + 8'd1;
    end
  end

  int n_cmp = 0, n_fail = 0;
  int done_cnt = 0, beat_cnt = 0, acc_cnt = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] cap_q [$];
  logic [DW-1:0] img   [NW];
  logic [DW-1:0] gexp  [NW];
  logic [DW-1:0] rnd   [4][NW];
  logic [DW-1:0] ck    [4][NW];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h expected no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          check("dump_word", out_data, e);
          cap_q.push_back(out_data);
        end
      end
      if (done) done_cnt++;
      if (cmd_valid && cmd_ready) acc_cnt++;
      if (busy && !done) check("halt_in_pass", 64'(emu_halt), 64'd1);
    end
  endtask

  function automatic logic [DW-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic load_now();
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic run_pass(input logic dir, output int cyc);
    @(posedge clk);
    #1 cmd_dir = dir;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 1;
    while (cyc < 1000) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 1000) check("pass_timeout", 64'(cyc), 64'd0);
  endtask

  task automatic dump_expect(input string nm);
    int cyc, b0, d0;
    b0 = beat_cnt;
    d0 = done_cnt;
    cap_q.delete();
    run_pass(DIR_DUMP, cyc);
    @(posedge clk);
    #1;
    check({nm, "_latency"}, 64'(cyc), 64'(1 + RDL + NW + 3));
    check({nm, "_beats"}, 64'(beat_cnt - b0), 64'(NW));
    check({nm, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({nm, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_restore(input logic gap);
    int cyc, d0;
    d0 = done_cnt;
    src_rst = 1'b1;
    @(posedge clk);
    #1 src_rst = 1'b0;
    src_en = 1'b1;
    gap_en = gap;
    run_pass(DIR_RESTORE, cyc);
    src_en = 1'b0;
    gap_en = 1'b0;
    @(posedge clk);
    #1;
    check("restore_xfer_cycles", 64'(rdy_cnt), 64'(NW));
    check("restore_done_once", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic wait_done(input int d0, input string nm);
    int k = 0;
    while (done_cnt == d0 && k < 1000) begin
      @(posedge clk);
      #1 k++;
    end
    if (k >= 1000) check({nm, "_timeout"}, 64'(k), 64'd0);
  endtask

  initial begin
    int d0, a0, k;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir = 1'b0;
    for (int i = 0; i < NW; i++) begin
      load_buf[i] = '0;
      src_buf[i]  = '0;
    end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 64'({busy, done, err_unf, emu_halt, ram_scan, ram_dir, out_valid, in_ready}), 64'd0);
    check("reset_out_data", out_data, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // Dump a random image, then scribble the RAM and restore the captured words.
    for (int i = 0; i < NW; i++) begin
      img[i] = rand64();
      load_buf[i] = img[i];
      exp_q.push_back(img[i]);
    end
    load_now();
    dump_expect("dump0");
    for (int i = 0; i < NW; i++) begin
      src_buf[i]  = (i < cap_q.size()) ? cap_q[i] : '0;
      load_buf[i] = rand64();
    end
    load_now();
    do_restore(1'b0);
    check("restore_err_unf_clear", 64'(err_unf), 64'd0);
    for (int i = 0; i < NW; i++) exp_q.push_back(img[i]);
    dump_expect("verify0");

    // Underrun on slot 5: a zero is shifted in and later words slip by one.
    for (int i = 0; i < NW; i++) src_buf[i] = 64'hA500_0000_0000_0000 | 64'(i);
    do_restore(1'b1);
    check("underrun_err_unf", 64'(err_unf), 64'd1);
    repeat (3) @(posedge clk);
    #1 check("underrun_err_sticky", 64'(err_unf), 64'd1);
    for (int i = 0; i < NW; i++)
      gexp[i] = (i < 5) ? src_buf[i] : (i == 5) ? 64'd0 : src_buf[i - 1];

    // cmd_valid held across a pass: exactly one accept per IDLE visit.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NW; i++) exp_q.push_back(gexp[i]);
    d0 = done_cnt;
    a0 = acc_cnt;
    @(posedge clk);
    #1 cmd_dir = DIR_DUMP;
    cmd_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("held_err_cleared", 64'(err_unf), 64'd0);
    check("held_busy", 64'(busy), 64'd1);
    wait_done(d0, "held_pass1");
    check("held_single_accept", 64'(acc_cnt - a0), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_done(d0 + 1, "held_pass2");
    @(posedge clk);
    #1;
    check("held_second_accept", 64'(acc_cnt - a0), 64'd2);
    check("held_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset asserted mid-transfer at word 40.
    for (int i = 0; i < NW; i++) src_buf[i] = rand64();
    src_rst = 1'b1;
    @(posedge clk);
    #1 src_rst = 1'b0;
    src_en = 1'b1;
    cmd_dir = DIR_RESTORE;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    k = 0;
    while (rdy_cnt < 8'd40 && k < 500) begin
      @(posedge clk);
      #1 k++;
    end
    check("rst_reached_word40", 64'(rdy_cnt), 64'd40);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", 64'({emu_halt, ram_scan, busy, in_ready}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    src_en = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);
    check("rst_idle", 64'({cmd_ready, busy}), 64'b10);

    // Four checkpoints taken, then each restored and read back.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NW; i++) begin
        rnd[r][i] = rand64();
        load_buf[i] = rnd[r][i];
        exp_q.push_back(rnd[r][i]);
      end
      load_now();
      dump_expect("round_dump");
      for (int i = 0; i < NW; i++) ck[r][i] = (i < cap_q.size()) ? cap_q[i] : '0;
    end
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NW; i++) begin
        load_buf[i] = rand64();
        src_buf[i]  = ck[r][i];
      end
      load_now();
      do_restore(1'b0);
      check("round_err_unf", 64'(err_unf), 64'd0);
      for (int i = 0; i < NW; i++) exp_q.push_back(rnd[r][i]);
      dump_expect("round_verify");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
